seq_shifter: RTL and testbench
==============================

# seq_shifter

Multi-cycle, parametrised barrel-shift engine for fixed-point scaling in the neural network datapath. It computes `base` shifted by `power` under a selectable mode: logical left, logical right, arithmetic right or rotate left. It works at a configurable number of bit positions per clock and uses a start/done handshake with an overflow flag. It generalises the 16-bit, left-shift-only shifter to arbitrary width, throughput and shift mode.

## Interface
- `WIDTH`, 16: data width of `base` and `result`.
- `POWER_W`, 16: width of the `power` (shift amount) input.
- `STEP`, 1: bit positions shifted per active cycle. Power of two, 1 ≤ STEP ≤ WIDTH.
- `clk`, in, 1: the single clock; all state changes on its rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `base`, in, WIDTH: operand, sampled on the accepting edge only.
- `power`, in, POWER_W: unsigned shift amount, sampled on the accepting edge only.
- `mode`, in, 2: 00 LSL, 01 LSR, 10 ASR, 11 ROL; sampled on the accepting edge only.
- `start`, in, 1: request; accepted on a rising edge while in IDLE.
- `result`, out, WIDTH: registered result; holds until the next completion.
- `done`, out, 1: one-cycle pulse; `result` and `overflow` are valid while it is high.
- `busy`, out, 1: high while an operation is in flight.
- `overflow`, out, 1: LSL only; set if any 1 bit was shifted out. Valid with `done` and held with `result`.

## Operation
- FSM has two states, IDLE and SHIFT.
- **IDLE, `start` = 1 at an edge:**
  - Load the accumulator with `base`, latch `mode`, load `cnt` with the effective count.
  - Clear the internal overflow flag, then go to SHIFT.
- **IDLE, `start` = 0:** no change.
- **SHIFT, `cnt` = 0:** `result` ← accumulator, `overflow` ← internal flag, `done` ← 1, go to IDLE.
- **SHIFT, `cnt` ≠ 0:** shift the accumulator by k = min(STEP, `cnt`); `cnt` ← `cnt` − k.
- **Effective count:**
  - LSL/LSR/ASR: min(`power`, WIDTH).
  - ROL: `power` mod WIDTH.
  - Arithmetic on `power` is unsigned, full POWER_W bits; no truncation before clamping.
- **Per-mode shift of k positions:**
  - LSL fills LSBs with 0 and ORs any shifted-out 1s into the overflow flag.
  - LSR fills MSBs with 0.
  - ASR fills MSBs with the latched sign bit (accumulator MSB).
  - ROL wraps MSBs into LSBs.
- **Clamp results (`power` ≥ WIDTH):**
  - LSL gives 0, with overflow = (`base` ≠ 0).
  - LSR gives 0.
  - ASR gives all sign bits.
- `start` while `busy` is ignored; no queueing.
- `base`, `power` and `mode` may change freely after the accepting edge.

## Timing
- **Reset values:** state IDLE, `result` 0, `done` 0, `busy` 0, `overflow` 0, `cnt` 0.
- **Latency:** `done` is high ceil(eff/STEP) + 1 rising edges after the accepting edge.
  - `power` = 0 (or ROL by a multiple of WIDTH) gives `done` on the 1st edge after accept, with `result` = `base`.
- **`busy`:** high from the accepting edge up to the completion edge. Low in the cycle `done` is high.
- **Back-to-back:** a new `start` may be accepted on the edge that ends the `done` cycle.
  - Max throughput is one operation per ceil(eff/STEP) + 2 cycles.
- **`done` pulse:** exactly one cycle; it never repeats without a new `start`.
- **Reset mid-operation:** immediate abort, outputs return to reset values, no `done` is issued.
- **Reset released with `start` = 1:** accepted on the first rising edge after deassertion.

## Test plan
1. WIDTH=16, STEP=1; `base`=0x0003, `power`=4, LSL → `done` on the 5th edge after accept; `result`=0x0030, `overflow`=0.
2. LSL, `base`=0x8001, `power`=1 → `result`=0x0002, `overflow`=1. Then LSL, `base`=0x0001, `power`=40 → `result`=0x0000, `overflow`=1, `done` on the 17th edge.
3. ASR, `base`=0xF000, `power`=20 → `result`=0xFFFF after 17 edges. LSR with the same inputs → 0x0000. ASR, `base`=0x7F00, `power`=4 → 0x07F0.
4. ROL, `base`=0x8001, `power`=17 → `result`=0x0003, `done` on the 2nd edge, `overflow`=0.
5. STEP=4; LSL, `base`=0x0001, `power`=6 → `result`=0x0040, `done` on the 3rd edge. `power`=0 → `result`=`base`, `done` on the 1st edge.
6. Control checks:
   - `start` pulsed while `busy` → ignored; the first result is unchanged.
   - `rst` asserted mid-SHIFT → `busy`/`done`/`result`/`overflow` = 0 immediately, no `done` follows.
   - `start` held high continuously → back-to-back operations spaced per the Timing rule.

Source files
------------

// File: rtl/seq_shifter.sv
// ============================================================================
// Module   : seq_shifter
// Brief    : Multi-cycle barrel shifter (LSL/LSR/ASR/ROL), STEP bits per clock,
//            start/done handshake with LSL overflow detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_shifter #(
  parameter int WIDTH   = 16,
  parameter int POWER_W = 16,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   i_base,
  input  logic [POWER_W-1:0] i_power,
  input  logic [1:0]         i_mode,
  input  logic               i_start,
  output logic [WIDTH-1:0]   o_result,
  output logic               o_done,
  output logic               o_busy,
  output logic               o_overflow
);

  localparam int c_CNT_W = $clog2(WIDTH + 1);
  localparam int c_EXT_W = (POWER_W > c_CNT_W) ? POWER_W : c_CNT_W;

  localparam logic [1:0] c_MODE_LSL = 2'b00;
  localparam logic [1:0] c_MODE_LSR = 2'b01;
  localparam logic [1:0] c_MODE_ASR = 2'b10;
  localparam logic [1:0] c_MODE_ROL = 2'b11;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]     w_acc_sh;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_k;
  logic [c_CNT_W-1:0]   w_eff;
  logic [1:0]           r_mode;
  logic                 r_ovf_int;
  logic                 w_ovf_sh;
  logic [WIDTH-1:0]     r_result;
  logic                 r_done;
  logic                 r_overflow;
  logic [c_EXT_W-1:0]   w_pow_ext;
  logic [c_EXT_W-1:0]   w_rol_amt;

  // Clamp is done on the full-width power so large amounts never alias small ones.
  assign w_pow_ext = c_EXT_W'(i_power);
  assign w_rol_amt = w_pow_ext % c_EXT_W'(WIDTH);

  always_comb begin
    w_eff = '0;
    if (i_mode == c_MODE_ROL) begin
      w_eff = c_CNT_W'(w_rol_amt);
    end else if (w_pow_ext >= c_EXT_W'(WIDTH)) begin
      w_eff = c_CNT_W'(WIDTH);
    end else begin
      w_eff = c_CNT_W'(w_pow_ext);
    end
  end

  assign w_k = (r_cnt > c_CNT_W'(STEP)) ? c_CNT_W'(STEP) : r_cnt;

  always_comb begin
    w_acc_sh = r_acc;
    w_ovf_sh = r_ovf_int;
    case (r_mode)
      c_MODE_LSL: begin
        w_acc_sh = r_acc << w_k;
        // Any 1 in the top k bits is about to fall off the MSB end.
        w_ovf_sh = r_ovf_int | (|(r_acc & ~({WIDTH{1'b1}} >> w_k)));
      end
      c_MODE_LSR: w_acc_sh = r_acc >> w_k;
      c_MODE_ASR: w_acc_sh = $signed(r_acc) >>> w_k;
      c_MODE_ROL: w_acc_sh = (r_acc << w_k) | (r_acc >> (c_CNT_W'(WIDTH) - w_k));
      default:    w_acc_sh = r_acc;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_SHIFT;
      S_SHIFT: if (r_cnt == '0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_mode     <= c_MODE_LSL;
      r_ovf_int  <= 1'b0;
      r_result   <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_acc     <= i_base;
            r_mode    <= i_mode;
            r_cnt     <= w_eff;
            r_ovf_int <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (r_cnt == '0) begin
            r_result   <= r_acc;
            r_overflow <= r_ovf_int;
            r_done     <= 1'b1;
          end else begin
            r_acc     <= w_acc_sh;
            r_cnt     <= r_cnt - w_k;
            r_ovf_int <= w_ovf_sh;
          end
        end
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign o_result   = r_result;
  assign o_done     = r_done;
  assign o_busy     = (r_state == S_SHIFT);
  assign o_overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_seq_shifter.sv
// ============================================================================
// Module   : tb_seq_shifter
// Brief    : Self-checking bench for seq_shifter (STEP=1 and STEP=4 instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] base;
  logic [15:0] power;
  logic [1:0]  mode;
  logic        start;
  logic [15:0] res0, res1;
  logic        done0, done1, busy0, busy1, ovf0, ovf1;
  bit          cmp_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(16), .POWER_W(16), .STEP(1)) u_dut0 (
    .clk(clk), .rst(rst), .i_base(base), .i_power(power), .i_mode(mode),
    .i_start(start), .o_result(res0), .o_done(done0), .o_busy(busy0),
    .o_overflow(ovf0)
  );

  seq_shifter #(.WIDTH(16), .POWER_W(16), .STEP(4)) u_dut1 (
    .clk(clk), .rst(rst), .i_base(base), .i_power(power), .i_mode(mode),
    .i_start(start), .o_result(res1), .o_done(done1), .o_busy(busy1),
    .o_overflow(ovf1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Whole-operation reference: the full shift computed in one go with wide arithmetic.
  function automatic void ref_op(input logic [15:0] b, input logic [15:0] p, input logic [1:0] m,
                                 output logic [15:0] r, output logic o, output int eff);
    logic [31:0] full;
    int          s;
    o = 1'b0;
    r = 16'h0;
    if (m == 2'b11) eff = int'(p % 16);
    else            eff = (p >= 16) ? 16 : int'(p);
    case (m)
      2'b00: begin full = {16'h0, b} << eff; r = full[15:0]; o = |full[31:16]; end
      2'b01: r = b >> eff;
      2'b10: begin s = int'($signed(b)); s = s >>> eff; r = s[15:0]; end
      default: begin full = {b, b} << eff; r = full[31:16]; end
    endcase
  endfunction

  int          steps [2] = '{1, 4};
  bit          m_busy [2] = '{0, 0};
  bit          m_done [2] = '{0, 0};
  int          m_left [2] = '{0, 0};
  logic [15:0] m_res  [2] = '{16'h0, 16'h0};
  logic        m_ovf  [2] = '{1'b0, 1'b0};
  logic [15:0] p_res  [2] = '{16'h0, 16'h0};
  logic        p_ovf  [2] = '{1'b0, 1'b0};

  always @(posedge clk or posedge rst) begin
    logic [15:0] t_r;
    logic        t_o;
    int          t_e;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] <= 1'b0; m_done[i] <= 1'b0; m_left[i] <= 0;
        m_res[i]  <= 16'h0; m_ovf[i] <= 1'b0;
      end
    end else begin
      ref_op(base, power, mode, t_r, t_o, t_e);
      for (int i = 0; i < 2; i++) begin
        m_done[i] <= 1'b0;
        if (m_busy[i]) begin
          m_left[i] <= m_left[i] - 1;
          if (m_left[i] == 1) begin
            m_busy[i] <= 1'b0;
            m_done[i] <= 1'b1;
            m_res[i]  <= p_res[i];
            m_ovf[i]  <= p_ovf[i];
          end
        end else if (start) begin
          m_busy[i] <= 1'b1;
          p_res[i]  <= t_r;
          p_ovf[i]  <= t_o;
          m_left[i] <= (t_e + steps[i] - 1) / steps[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp0_done",   done0, m_done[0]);
      check("cmp0_busy",   busy0, m_busy[0]);
      check("cmp0_result", res0,  m_res[0]);
      check("cmp0_ovf",    ovf0,  m_ovf[0]);
      check("cmp1_done",   done1, m_done[1]);
      check("cmp1_busy",   busy1, m_busy[1]);
      check("cmp1_result", res1,  m_res[1]);
      check("cmp1_ovf",    ovf1,  m_ovf[1]);
    end
  end

  task automatic directed(input string name, input logic [15:0] b, input logic [15:0] p,
                          input logic [1:0] m, input logic [15:0] er, input logic eo,
                          input int l0, input int l1, input bit poke);
    int          g0, g1;
    logic [15:0] r0, r1;
    logic        o0, o1;
    g0 = -1; g1 = -1; r0 = 16'h0; r1 = 16'h0; o0 = 1'b0; o1 = 1'b0;
    @(negedge clk);
    base = b; power = p; mode = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0; base = 16'($urandom); power = 16'($urandom); mode = 2'($urandom);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done0 && g0 < 0) begin g0 = n; r0 = res0; o0 = ovf0; end
      if (done1 && g1 < 0) begin g1 = n; r1 = res1; o1 = ovf1; end
      if (poke && n == 1) begin start = 1'b1; base = 16'hFFFF; power = 16'h0; mode = 2'b00; end
      if (poke && n == 2) start = 1'b0;
      if (g0 >= 0 && g1 >= 0) break;
    end
    start = 1'b0;
    check({name, "_lat_s1"}, g0, l0);
    check({name, "_res_s1"}, r0, er);
    check({name, "_ovf_s1"}, o0, eo);
    check({name, "_lat_s4"}, g1, l1);
    check({name, "_res_s4"}, r1, er);
    check({name, "_ovf_s4"}, o1, eo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] mr;
    logic        mo;
    int          me;
    int          d0 [2];
    int          d1 [2];
    int          nd0, nd1, stray;

    rst = 1'b1; start = 1'b0; base = 16'h0; power = 16'h0; mode = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_result0", res0, 16'h0); check("rst_done0", done0, 1'b0);
    check("rst_busy0", busy0, 1'b0);   check("rst_ovf0", ovf0, 1'b0);
    check("rst_result1", res1, 16'h0); check("rst_busy1", busy1, 1'b0);
    rst = 1'b0;
    cmp_en = 1'b1;

    ref_op(16'h0003, 16'd4, 2'b00, mr, mo, me);  check("model_lsl", mr, 16'h0030);
    ref_op(16'hF000, 16'd20, 2'b10, mr, mo, me); check("model_asr", mr, 16'hFFFF);
    ref_op(16'h8001, 16'd17, 2'b11, mr, mo, me); check("model_rol", mr, 16'h0003);
    ref_op(16'h0001, 16'd40, 2'b00, mr, mo, me); check("model_ovf", mo, 1'b1);

    directed("lsl_3_4",     16'h0003, 16'd4,  2'b00, 16'h0030, 1'b0, 5,  2, 1'b0);
    directed("lsl_8001_1",  16'h8001, 16'd1,  2'b00, 16'h0002, 1'b1, 2,  2, 1'b0);
    directed("lsl_1_40",    16'h0001, 16'd40, 2'b00, 16'h0000, 1'b1, 17, 5, 1'b0);
    directed("asr_f000_20", 16'hF000, 16'd20, 2'b10, 16'hFFFF, 1'b0, 17, 5, 1'b0);
    directed("lsr_f000_20", 16'hF000, 16'd20, 2'b01, 16'h0000, 1'b0, 17, 5, 1'b0);
    directed("asr_7f00_4",  16'h7F00, 16'd4,  2'b10, 16'h07F0, 1'b0, 5,  2, 1'b0);
    directed("rol_8001_17", 16'h8001, 16'd17, 2'b11, 16'h0003, 1'b0, 2,  2, 1'b0);
    directed("lsl_1_6",     16'h0001, 16'd6,  2'b00, 16'h0040, 1'b0, 7,  3, 1'b0);
    directed("pow0",        16'hBEEF, 16'd0,  2'b01, 16'hBEEF, 1'b0, 1,  1, 1'b0);
    directed("rol_16",      16'h1234, 16'd16, 2'b11, 16'h1234, 1'b0, 1,  1, 1'b0);
    directed("busy_poke",   16'h0003, 16'd4,  2'b00, 16'h0030, 1'b0, 5,  2, 1'b1);

    // Asynchronous abort in the middle of a shift.
    @(negedge clk);
    base = 16'h0003; power = 16'd10; mode = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy0", busy0, 1'b0); check("abort_result0", res0, 16'h0);
    check("abort_done0", done0, 1'b0); check("abort_ovf0", ovf0, 1'b0);
    check("abort_busy1", busy1, 1'b0); check("abort_result1", res1, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (done0 || done1) stray++;
    end
    check("abort_no_done", stray, 0);

    // Start held high across reset release: back-to-back operations.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; base = 16'h0003; power = 16'd4; mode = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    nd0 = 0; nd1 = 0; d0 = '{-1, -1}; d1 = '{-1, -1};
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (done0 && nd0 < 2) begin d0[nd0] = n; nd0++; end
      if (done1 && nd1 < 2) begin d1[nd1] = n; nd1++; end
    end
    start = 1'b0;
    check("b2b_first_s1", d0[0], 6);
    check("b2b_gap_s1", d0[1] - d0[0], 6);
    check("b2b_first_s4", d1[0], 3);
    check("b2b_gap_s4", d1[1] - d1[0], 3);
    repeat (20) @(negedge clk);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0:       base = 16'h0000;
        1:       base = 16'h8000;
        2:       base = 16'hFFFF;
        default: base = 16'($urandom);
      endcase
      power = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
      mode  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 599) == 0) begin
        #1 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    start = 1'b0;
    repeat (25) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
